color_sensor_emulator: RTL and testbench
========================================

Name: color_sensor_emulator

Overview:
Behavioural-synthesizable model of a TCS3200-style light-to-frequency colour sensor, the emitting end of the filter-select/frequency interface used by the colour-identification reader. It takes the filter-select lines driven by the reader and produces a square-wave `frequency` output. The output's half-period is set by programmable per-channel intensity registers. It is used on-board for closed-loop self-test and in simulation as the sensor stand-in.

Parameters:
DIV_W, 16, width of each per-channel half-period input (cycles).
SETTLE_CYCLES, 8, clk cycles the output is held low after a filter change (photodiode settle), ≥1.
CNT_W, 16, width of edge_count.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  sensor output enable (OE); low forces output off.
filter_select  in  2  from reader, asynchronous to clk: 00 red, 11 green, 10 blue, 01 clear.
freq_scale  in  2  S0/S1 scaling: 00 power-down, 01 half-period<<4, 10 <<2, 11 <<0.
red_half  in  DIV_W  red half-period base value.
green_half  in  DIV_W  green half-period base value.
blue_half  in  DIV_W  blue half-period base value.
clear_half  in  DIV_W  clear half-period base value.
frequency  out  1  square-wave sensor output.
active_channel  out  2  synchronized filter code currently in effect.
settling  out  1  high while in SETTLE.
edge_count  out  CNT_W  rising edges of frequency since last SETTLE/OFF entry, saturating.

Behaviour:
- Reset (async assert, sync-free release):
  - frequency=0, active_channel=00, settling=0, edge_count=0.
  - State OFF; synchronizer flops = 00.
- filter_select passes through a 2-flop synchronizer.
  - A change in the synchronized value versus active_channel is detected the next cycle.
  - Total: 3 clk from input change to SETTLE entry.
- Effective half-period: H = selected_half << shift(freq_scale), width DIV_W+4, no overflow possible.
- State machine:
  - OFF:
    - Entered when enable=0 or freq_scale=00; these conditions override every other state immediately (next edge).
    - frequency=0, half counter=0, edge_count=0.
    - Exit to SETTLE when enable=1 and freq_scale≠00.
  - SETTLE:
    - settling=1, frequency=0, edge_count cleared on entry.
    - active_channel updated on entry.
    - Counts SETTLE_CYCLES cycles, then goes to RUN.
    - A further filter change restarts the settle count.
  - RUN:
    - On entry, H is latched, counter=0, frequency=0.
    - When counter reaches H−1: toggle frequency, reload counter=0, re-latch H for the new half-cycle. Changes to *_half or freq_scale therefore take effect only at the next toggle.
    - Resulting waveform: period 2H, 50% duty.
    - H==0: frequency held 0, no toggles, re-latched every cycle until nonzero.
    - Filter change → SETTLE; frequency forced 0 the same edge it enters SETTLE.
- edge_count:
  - Increments on the cycle frequency goes 0→1.
  - Saturates at all-ones.
- Simultaneous events, priority: OFF condition > filter change > toggle.

Test Plan:
1. Reset with rst_n low mid-cycle → all outputs 0 asynchronously; after release with enable=1, freq_scale=11, select 00, red_half=10 → SETTLE for 8 cycles, then frequency toggles every 10 cycles (period 20), edge_count counts 1,2,3…
2. In RUN with red, switch filter_select to 11 (green_half=25) → settling rises 3 cycles later; frequency low for 8 cycles; then period 50; edge_count restarts at 0.
3. freq_scale=10 with blue_half=6, select 10 → period 48; switch freq_scale to 01 mid-half-cycle → current half completes at 24, subsequent half-periods 96.
4. Set clear_half=0, select 01 → frequency stays 0 indefinitely, edge_count=0; then write clear_half=3 → toggling at half-period 3.
5. Drop enable while frequency=1 → next edge frequency=0, edge_count=0; re-raise enable → full SETTLE before oscillation.
6. Hold edges until edge_count=0xFFFF (red_half=1) → edge_count stays 0xFFFF; assert rst_n low mid-high-phase → frequency=0 immediately.

Source files
------------

// File: rtl/color_sensor_emulator.sv
// -----------------------------------------------------------------------------
// color_sensor_emulator
//
// Synthesizable stand-in for a TCS3200-style light-to-frequency colour sensor.
// The reader drives the filter-select lines; this block answers with a 50 %
// duty square wave whose half-period comes from a per-channel intensity
// register, scaled by the S0/S1 frequency-scaling code.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   enable         output enable; low forces the sensor off
//   filter_select  filter code from the reader (asynchronous to clk):
//                  00 red, 11 green, 10 blue, 01 clear
//   freq_scale     00 power-down, 01 half<<4, 10 half<<2, 11 half<<0
//   red_half       red   half-period base value (clk cycles)
//   green_half     green half-period base value
//   blue_half      blue  half-period base value
//   clear_half     clear half-period base value
//   frequency      square-wave sensor output
//   active_channel synchronized filter code currently in effect
//   settling       high while the photodiode settle window is running
//   edge_count     rising edges of frequency since the last SETTLE/OFF entry,
//                  saturating at all-ones
// -----------------------------------------------------------------------------
module color_sensor_emulator #(
    parameter int DIV_W         = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       filter_select,
    input  logic [1:0]       freq_scale,
    input  logic [DIV_W-1:0] red_half,
    input  logic [DIV_W-1:0] green_half,
    input  logic [DIV_W-1:0] blue_half,
    input  logic [DIV_W-1:0] clear_half,
    output logic             frequency,
    output logic [1:0]       active_channel,
    output logic             settling,
    output logic [CNT_W-1:0] edge_count
);

    // Effective half-period needs four extra bits for the largest shift.
    localparam int HW  = DIV_W + 4;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [HW-1:0]    HALF_ONE   = HW'(1);
    localparam logic [CNT_W-1:0] EDGE_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] EDGE_SAT   = '1;
    localparam logic [SCW-1:0]   SETTLE_END = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0]   SETTLE_ONE = SCW'(1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Selects the channel base value and applies the S0/S1 scaling shift.
    function automatic logic [HW-1:0] eff_half(
        input logic [1:0]       code,
        input logic [1:0]       scale,
        input logic [DIV_W-1:0] r,
        input logic [DIV_W-1:0] g,
        input logic [DIV_W-1:0] b,
        input logic [DIV_W-1:0] c
    );
        logic [DIV_W-1:0] base;
        logic [HW-1:0]    wide;
        case (code)
            2'b00:   base = r;
            2'b11:   base = g;
            2'b10:   base = b;
            default: base = c;
        endcase
        wide = HW'(base);
        case (scale)
            2'b01:   eff_half = wide << 4;
            2'b10:   eff_half = wide << 2;
            2'b11:   eff_half = wide;
            default: eff_half = '0;
        endcase
    endfunction

    state_t           state_q;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       active_q;
    logic [SCW-1:0]   settle_cnt_q;
    logic [HW-1:0]    half_q;
    logic [HW-1:0]    cnt_q;
    logic             freq_q;
    logic             settling_q;
    logic [CNT_W-1:0] edge_cnt_q;

    logic [HW-1:0]    half_d;
    logic             off_req;
    logic             chan_change;
    logic             half_done;

    // Two-flop synchronizer for the reader's filter lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= filter_select;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        half_d      = eff_half(active_q, freq_scale, red_half, green_half,
                               blue_half, clear_half);
        off_req     = !enable || (freq_scale == 2'b00);
        chan_change = (sync2_q != active_q);
        half_done   = (cnt_q == half_q - HALF_ONE);
    end

    // Sensor state machine. Priority: off request > filter change > toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            active_q     <= 2'b00;
            settle_cnt_q <= '0;
            half_q       <= '0;
            cnt_q        <= '0;
            freq_q       <= 1'b0;
            settling_q   <= 1'b0;
            edge_cnt_q   <= '0;
        end else if (off_req) begin
            state_q      <= ST_OFF;
            settle_cnt_q <= '0;
            cnt_q        <= '0;
            freq_q       <= 1'b0;
            settling_q   <= 1'b0;
            edge_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_q      <= ST_SETTLE;
                    active_q     <= sync2_q;
                    settle_cnt_q <= '0;
                    cnt_q        <= '0;
                    freq_q       <= 1'b0;
                    settling_q   <= 1'b1;
                    edge_cnt_q   <= '0;
                end

                ST_SETTLE: begin
                    if (chan_change) begin
                        // A new filter restarts the settle window.
                        active_q     <= sync2_q;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == SETTLE_END) begin
                        state_q    <= ST_RUN;
                        settling_q <= 1'b0;
                        half_q     <= half_d;
                        cnt_q      <= '0;
                        freq_q     <= 1'b0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SETTLE_ONE;
                    end
                end

                ST_RUN: begin
                    if (chan_change) begin
                        state_q      <= ST_SETTLE;
                        active_q     <= sync2_q;
                        settle_cnt_q <= '0;
                        cnt_q        <= '0;
                        freq_q       <= 1'b0;
                        settling_q   <= 1'b1;
                        edge_cnt_q   <= '0;
                    end else if (half_q == '0) begin
                        // Zero intensity: stay low and keep sampling until nonzero.
                        half_q <= half_d;
                        cnt_q  <= '0;
                        freq_q <= 1'b0;
                    end else if (half_done) begin
                        // Half-period boundary: new settings are picked up only here.
                        freq_q <= ~freq_q;
                        cnt_q  <= '0;
                        half_q <= half_d;
                        if (!freq_q && (edge_cnt_q != EDGE_SAT)) begin
                            edge_cnt_q <= edge_cnt_q + EDGE_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + HALF_ONE;
                    end
                end

                default: begin
                    state_q    <= ST_OFF;
                    freq_q     <= 1'b0;
                    settling_q <= 1'b0;
                end
            endcase
        end
    end

    assign frequency      = freq_q;
    assign active_channel = active_q;
    assign settling       = settling_q;
    assign edge_count     = edge_cnt_q;

endmodule

// File: tb/tb_color_sensor_emulator.sv
module tb_color_sensor_emulator;

    localparam int DIV_W = 16;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 10;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [1:0]       filter_select;
    logic [1:0]       freq_scale;
    logic [DIV_W-1:0] red_half;
    logic [DIV_W-1:0] green_half;
    logic [DIV_W-1:0] blue_half;
    logic [DIV_W-1:0] clear_half;
    logic             frequency;
    logic [1:0]       active_channel;
    logic             settling;
    logic [CNT_W-1:0] edge_count;

    color_sensor_emulator #(
        .DIV_W(DIV_W),
        .SETTLE_CYCLES(8),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .filter_select(filter_select),
        .freq_scale(freq_scale),
        .red_half(red_half),
        .green_half(green_half),
        .blue_half(blue_half),
        .clear_half(clear_half),
        .frequency(frequency),
        .active_channel(active_channel),
        .settling(settling),
        .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frequency transition: new level, cycles since the previous
    // reference point (settle end or prior transition), edge_count after it.
    typedef struct {
        bit lvl;
        int gap;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ncyc = 0;
    int   mon_ref = 0;
    bit   mon_en = 0;
    logic prev_f = 1'b0;
    logic prev_s = 1'b0;

    // Monitor: every frequency transition outside SETTLE is checked against
    // the head of the scoreboard.
    always @(negedge clk) begin
        ncyc++;
        if (!settling && prev_s) begin
            mon_ref = ncyc;
        end else if (!settling && (frequency !== prev_f)) begin
            if (mon_en) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_edge: got level %0b at gap %0d, required no edge",
                             frequency, ncyc - mon_ref);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (frequency !== e.lvl || (ncyc - mon_ref) != e.gap ||
                        int'(edge_count) != e.cnt) begin
                        fails++;
                        $display("FAIL edge lvl/gap/cnt: got %0b/%0d/%0d, required %0b/%0d/%0d",
                                 frequency, ncyc - mon_ref, edge_count, e.lvl, e.gap, e.cnt);
                    end
                end
            end
            mon_ref = ncyc;
        end
        prev_f = frequency;
        prev_s = settling;
    end

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_periods(input int first_cnt, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            int c;
            c = (first_cnt + i > SAT) ? SAT : first_cnt + i;
            sb.push_back('{lvl: 1'b1, gap: half, cnt: c});
            sb.push_back('{lvl: 1'b0, gap: half, cnt: c});
        end
    endtask

    // Returns on a rising clock edge once the scoreboard is empty.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        mon_en = 0;
        chk({name, "_drain_left"}, sb.size(), 0);
        sb.delete();
    endtask

    // Call just after driving a new filter code (posedge + 1).
    task automatic wait_filter(input string name, input logic [1:0] code);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_settle_not_early"}, settling, 0);
        @(posedge clk);
        #1;
        chk({name, "_settle_at_3"}, settling, 1);
        chk({name, "_freq_in_settle"}, frequency, 0);
        chk({name, "_count_cleared"}, edge_count, 0);
        chk({name, "_active"}, active_channel, code);
    endtask

    task automatic wait_settle_rise(input string name);
        int n;
        n = 0;
        while (!settling && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_settle_seen"}, settling, 1);
    endtask

    task automatic settle_len(input string name);
        int n;
        n = 1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            if (!settling) break;
            n++;
        end
        chk({name, "_settle_len"}, n, 8);
    endtask

    initial begin
        rst_n         = 1'b1;
        enable        = 1'b1;
        freq_scale    = 2'b11;
        filter_select = 2'b00;
        red_half      = 16'd10;
        green_half    = 16'd25;
        blue_half     = 16'd6;
        clear_half    = 16'd0;

        // Test 1: asynchronous reset mid-cycle, then red at half-period 10.
        #12;
        rst_n = 1'b0;
        #1;
        chk("t1_reset_freq", frequency, 0);
        chk("t1_reset_active", active_channel, 0);
        chk("t1_reset_settling", settling, 0);
        chk("t1_reset_count", edge_count, 0);
        repeat (2) @(negedge clk);
        push_periods(1, 3, 10);
        mon_en = 1;
        rst_n = 1'b1;
        wait_settle_rise("t1");
        settle_len("t1");
        drain("t1", 200);

        // Test 2: switch to green (half 25).
        #1;
        filter_select = 2'b11;
        wait_filter("t2", 2'b11);
        push_periods(1, 3, 25);
        mon_en = 1;
        drain("t2", 300);

        // Test 3: blue 6 at scale <<2 = 24, then scale <<4 mid high half.
        #1;
        filter_select = 2'b10;
        freq_scale    = 2'b10;
        wait_filter("t3", 2'b10);
        sb.push_back('{lvl: 1'b1, gap: 24, cnt: 1});
        sb.push_back('{lvl: 1'b0, gap: 24, cnt: 1});
        sb.push_back('{lvl: 1'b1, gap: 24, cnt: 2});
        mon_en = 1;
        drain("t3a", 200);
        #1;
        freq_scale = 2'b01;
        sb.push_back('{lvl: 1'b0, gap: 24, cnt: 2});
        sb.push_back('{lvl: 1'b1, gap: 96, cnt: 3});
        sb.push_back('{lvl: 1'b0, gap: 96, cnt: 3});
        mon_en = 1;
        drain("t3b", 400);

        // Test 4: clear with zero intensity stays low, then half 3.
        #1;
        filter_select = 2'b01;
        freq_scale    = 2'b11;
        clear_half    = 16'd0;
        wait_filter("t4", 2'b01);
        mon_en = 1;
        repeat (100) @(posedge clk);
        #1;
        chk("t4_zero_freq", frequency, 0);
        chk("t4_zero_count", edge_count, 0);
        chk("t4_zero_running", settling, 0);
        clear_half = 16'd3;
        // Relatch on the next edge, then three counting edges to the first rise.
        mon_ref = ncyc + 1;
        sb.push_back('{lvl: 1'b1, gap: 4, cnt: 1});
        sb.push_back('{lvl: 1'b0, gap: 3, cnt: 1});
        sb.push_back('{lvl: 1'b1, gap: 3, cnt: 2});
        drain("t4", 50);

        // Test 5: drop enable while high, then re-enable.
        #1;
        chk("t5_high_before_drop", frequency, 1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_off_freq", frequency, 0);
        chk("t5_off_count", edge_count, 0);
        chk("t5_off_settling", settling, 0);
        repeat (3) @(posedge clk);
        #1;
        push_periods(1, 2, 3);
        mon_en = 1;
        enable = 1'b1;
        wait_settle_rise("t5");
        settle_len("t5");
        drain("t5", 100);

        // Test 6: red half 1 until edge_count saturates, then reset while high.
        #1;
        red_half      = 16'd1;
        filter_select = 2'b00;
        wait_filter("t6", 2'b00);
        push_periods(1, SAT + 7, 1);
        mon_en = 1;
        drain("t6", 2500);
        #1;
        chk("t6_high", frequency, 1);
        chk("t6_saturated", edge_count, SAT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_freq", frequency, 0);
        chk("t6_async_count", edge_count, 0);
        chk("t6_async_settling", settling, 0);
        chk("t6_async_active", active_channel, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
